// File: rtl/dsa_bilineal_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dsa_bilineal_pkg
//  Description : Shared defaults, fill-state encoding and word-count helper
//                for the bilinear line-fill datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package dsa_bilineal_pkg;

    localparam int LINE_WIDTH_DEF = 512;
    localparam int MEM_AW_DEF     = 20;
    localparam int WORD_IDX_W     = 10;

    typedef enum logic [1:0] {
        FILL_IDLE = 2'd0,
        FILL_REQ  = 2'd1,
        FILL_WAIT = 2'd2,
        FILL_FIN  = 2'd3
    } fill_state_t;

    // Number of 4-pixel words covering a row, rounded up
    function automatic logic [WORD_IDX_W-1:0] words_for_width(input logic [10:0] width);
        logic [11:0] sum;
        sum = {1'b0, width} + 12'd3;
        return sum[11:2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/row_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : row_addr_gen
//  Description : Registers the row offset (row * stride) once per source row
//                so the per-word address is a plain add.
//  Revision    : 1.0 - initial release
// ============================================================================
module row_addr_gen #(
    parameter int AW = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [9:0]    row,
    input  logic [AW-1:0] stride,
    output logic [AW-1:0] row_off
);

    // Capture the row offset, truncated to the memory address width
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_off <= '0;
        end else if (load) begin
            row_off <= AW'(row) * stride;
        end
    end

endmodule
`default_nettype wire

// File: rtl/line_fill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : line_fill_ctrl
//  Description : Fetches two adjacent image rows (y and y+1, edge-replicated)
//                from word memory into two line buffers, one read in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_fill_ctrl
    import dsa_bilineal_pkg::*;
#(
    parameter int LINE_WIDTH = LINE_WIDTH_DEF,
    parameter int MEM_AW     = MEM_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MEM_AW-1:0] cfg_base,
    input  logic [MEM_AW-1:0] cfg_stride,
    input  logic [10:0]       cfg_width,
    input  logic [9:0]        cfg_height,
    input  logic [9:0]        cfg_row,
    output logic              mem_rd_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic              mem_rd_valid,
    input  logic [31:0]       mem_rd_data,
    output logic              lb0_wr_en,
    output logic              lb1_wr_en,
    output logic [9:0]        lb_wr_addr,
    output logic [31:0]       lb_wr_data,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    localparam logic [WORD_IDX_W-1:0] LINE_WORDS = WORD_IDX_W'(LINE_WIDTH / 4);

    fill_state_t             state;
    fill_state_t             state_nxt;
    logic [MEM_AW-1:0]       base_q;
    logic [MEM_AW-1:0]       stride_q;
    logic [MEM_AW-1:0]       row_off;
    logic [WORD_IDX_W-1:0]   words_q;
    logic [WORD_IDX_W-1:0]   word_idx;
    logic [9:0]              row_b_q;
    logic                    row_sel;

    logic [WORD_IDX_W-1:0]   words_raw;
    logic [WORD_IDX_W-1:0]   words_calc;
    logic                    clamp;
    logic [10:0]             row_next;
    logic [9:0]              row_last;
    logic [9:0]              row_b_calc;
    logic                    accept;
    logic                    last_word;
    logic                    row_load;
    logic [9:0]              load_row;
    logic [MEM_AW-1:0]       load_stride;

    // Config-derived word count, clamp flag and edge-replicated second row
    always_comb begin
        words_raw  = words_for_width(cfg_width);
        clamp      = (words_raw > LINE_WORDS);
        words_calc = clamp ? LINE_WORDS : words_raw;
        row_next   = {1'b0, cfg_row} + 11'd1;
        row_last   = cfg_height - 10'd1;
        row_b_calc = (row_next > {1'b0, row_last}) ? row_last : row_next[9:0];
    end

    assign accept    = (state == FILL_WAIT) && mem_rd_valid;
    assign last_word = (word_idx == (words_q - 10'd1));

    // Row offset is refreshed at start (row y) and at the row-0 to row-1 switch
    assign row_load    = ((state == FILL_IDLE) && start) || (accept && last_word && !row_sel);
    assign load_row    = (state == FILL_IDLE) ? cfg_row : row_b_q;
    assign load_stride = (state == FILL_IDLE) ? cfg_stride : stride_q;

    row_addr_gen #(
        .AW (MEM_AW)
    ) u_row_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (row_load),
        .row     (load_row),
        .stride  (load_stride),
        .row_off (row_off)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived outputs
    always_comb begin
        state_nxt = state;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            FILL_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (words_calc == '0) ? FILL_FIN : FILL_REQ;
                end
            end
            FILL_REQ: begin
                mem_rd_en = 1'b1;
                mem_addr  = base_q + row_off + MEM_AW'(word_idx);
                state_nxt = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (mem_rd_valid) begin
                    state_nxt = (last_word && row_sel) ? FILL_FIN : FILL_REQ;
                end
            end
            FILL_FIN: begin
                done      = 1'b1;
                state_nxt = FILL_IDLE;
            end
            default: begin
                state_nxt = FILL_IDLE;
            end
        endcase
    end

    // Config latch, word/row walk and registered line-buffer write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q     <= '0;
            stride_q   <= '0;
            words_q    <= '0;
            row_b_q    <= '0;
            row_sel    <= 1'b0;
            word_idx   <= '0;
            cfg_err    <= 1'b0;
            lb0_wr_en  <= 1'b0;
            lb1_wr_en  <= 1'b0;
            lb_wr_addr <= '0;
            lb_wr_data <= '0;
        end else begin
            lb0_wr_en <= 1'b0;
            lb1_wr_en <= 1'b0;
            if ((state == FILL_IDLE) && start) begin
                base_q   <= cfg_base;
                stride_q <= cfg_stride;
                words_q  <= words_calc;
                cfg_err  <= clamp;
                row_b_q  <= row_b_calc;
                row_sel  <= 1'b0;
                word_idx <= '0;
            end
            if (accept) begin
                lb0_wr_en  <= ~row_sel;
                lb1_wr_en  <= row_sel;
                lb_wr_addr <= word_idx;
                lb_wr_data <= mem_rd_data;
                if (last_word) begin
                    word_idx <= '0;
                    row_sel  <= 1'b1;
                end else begin
                    word_idx <= word_idx + 10'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_line_fill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_fill_ctrl
//  Description : Directed self-checking bench for line_fill_ctrl with a
//                word-memory responder of selectable latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_line_fill_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [19:0] cfg_base;
    logic [19:0] cfg_stride;
    logic [10:0] cfg_width;
    logic [9:0]  cfg_height;
    logic [9:0]  cfg_row;
    logic        mem_rd_en;
    logic [19:0] mem_addr;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_data;
    logic        lb0_wr_en;
    logic        lb1_wr_en;
    logic [9:0]  lb_wr_addr;
    logic [31:0] lb_wr_data;
    logic        busy;
    logic        done;
    logic        cfg_err;

    logic        resp_valid;
    logic [31:0] resp_data;
    logic        spur_valid;
    logic [31:0] spur_data;
    logic [19:0] resp_addr;
    int          resp_lat;
    int          lat_mode;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rd_total = 0;
    int wr0_total = 0;
    int wr1_total = 0;
    int done_total = 0;
    int done_cyc = 0;
    int rd_b2b = 0;
    int dual_wr = 0;
    logic        rd_prev;
    logic        done_with_wr;
    logic [9:0]  last_wr_addr;
    logic [19:0] rd_log  [0:4095];
    logic [31:0] lb0_img [0:1023];
    logic [31:0] lb1_img [0:1023];

    assign mem_rd_valid = resp_valid | spur_valid;
    assign mem_rd_data  = resp_valid ? resp_data : spur_data;

    line_fill_ctrl #(
        .LINE_WIDTH (512),
        .MEM_AW     (20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_base     (cfg_base),
        .cfg_stride   (cfg_stride),
        .cfg_width    (cfg_width),
        .cfg_height   (cfg_height),
        .cfg_row      (cfg_row),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .lb0_wr_en    (lb0_wr_en),
        .lb1_wr_en    (lb1_wr_en),
        .lb_wr_addr   (lb_wr_addr),
        .lb_wr_data   (lb_wr_data),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    // Memory contents as a function of the word address
    function automatic logic [31:0] pix(input logic [19:0] a);
        return {a[7:0] ^ 8'h3C, a[15:8] + a[7:0], ~a[7:0], a[7:0] + 8'h11};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Memory responder: one read at a time, latency chosen by lat_mode
    initial begin
        resp_valid = 1'b0;
        resp_data  = '0;
        forever begin
            @(negedge clk);
            if (mem_rd_en) begin
                resp_addr = mem_addr;
                resp_lat  = (lat_mode == 1) ? int'($urandom_range(0, 5)) :
                            (lat_mode == 2) ? 3 : 0;
                repeat (resp_lat + 1) @(posedge clk);
                #1;
                resp_valid = 1'b1;
                resp_data  = pix(resp_addr);
                @(posedge clk);
                #1;
                resp_valid = 1'b0;
            end
        end
    end

    // Observer: logs reads, line-buffer writes and done pulses
    initial begin
        rd_prev = 1'b0;
        done_with_wr = 1'b0;
        last_wr_addr = '0;
        forever begin
            @(negedge clk);
            if (mem_rd_en) begin
                rd_log[rd_total] = mem_addr;
                rd_total++;
                if (rd_prev) rd_b2b++;
            end
            rd_prev = mem_rd_en;
            if (lb0_wr_en && lb1_wr_en) dual_wr++;
            if (lb0_wr_en) begin
                lb0_img[lb_wr_addr] = lb_wr_data;
                wr0_total++;
                last_wr_addr = lb_wr_addr;
            end
            if (lb1_wr_en) begin
                lb1_img[lb_wr_addr] = lb_wr_data;
                wr1_total++;
                last_wr_addr = lb_wr_addr;
            end
            if (done) begin
                done_total++;
                done_cyc = cyc;
                done_with_wr = lb0_wr_en | lb1_wr_en;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    task automatic pulse_start(input logic [10:0] w, input logic [9:0] h, input logic [9:0] r,
                               input logic [19:0] b, input logic [19:0] s, input bit record);
        @(posedge clk);
        #1;
        cfg_width  = w;
        cfg_height = h;
        cfg_row    = r;
        cfg_base   = b;
        cfg_stride = s;
        start      = 1'b1;
        if (record) start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int limit, input string tag);
        int n;
        n = 0;
        while (done_total == d0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_total == d0) begin
            errors++;
            $display("FAIL %s_timeout: no done within %0d cycles, required one done pulse", tag, limit);
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [67:0] obs;
        repeat (2) @(negedge clk);
        obs = {mem_rd_en, mem_addr, lb0_wr_en, lb1_wr_en, lb_wr_addr, lb_wr_data, busy, done, cfg_err};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, expected 0", obs);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b done=%b rd_en=%b, expected 0 0 0", busy, done, mem_rd_en);
        end
    endtask

    task automatic test_basic;
        int r0, w00, w10, d0;
        logic [19:0] ea;
        r0 = rd_total; w00 = wr0_total; w10 = wr1_total; d0 = done_total;
        lat_mode = 0;
        pulse_start(11'd16, 10'd8, 10'd2, 20'h00100, 20'h00004, 1'b1);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got %b, expected 1", busy);
        end
        wait_done(d0, 200, "basic");
        checks++;
        if (rd_total - r0 != 8) begin
            errors++;
            $display("FAIL basic_reads: got %0d, expected 8", rd_total - r0);
        end
        for (int k = 0; k < 8; k++) begin
            ea = 20'h00108 + 20'(k);
            checks++;
            if (rd_log[r0 + k] !== ea) begin
                errors++;
                $display("FAIL basic_addr[%0d]: got %h, expected %h", k, rd_log[r0 + k], ea);
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (lb0_img[k] !== pix(20'h00108 + 20'(k)) || lb1_img[k] !== pix(20'h0010C + 20'(k))) begin
                errors++;
                $display("FAIL basic_data[%0d]: got %h/%h, expected %h/%h", k, lb0_img[k], lb1_img[k],
                         pix(20'h00108 + 20'(k)), pix(20'h0010C + 20'(k)));
            end
        end
        checks++;
        if (wr0_total - w00 != 4 || wr1_total - w10 != 4) begin
            errors++;
            $display("FAIL basic_writes: got %0d/%0d, expected 4/4", wr0_total - w00, wr1_total - w10);
        end
        checks++;
        if (done_cyc - start_cyc != 17) begin
            errors++;
            $display("FAIL basic_latency: got %0d, expected 17", done_cyc - start_cyc);
        end
        checks++;
        if (done_with_wr !== 1'b1) begin
            errors++;
            $display("FAIL basic_done_with_write: got %b, expected 1", done_with_wr);
        end
        checks++;
        if (cfg_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_flags: cfg_err=%b busy=%b, expected 0 0", cfg_err, busy);
        end
        checks++;
        if (rd_b2b != 0 || dual_wr != 0) begin
            errors++;
            $display("FAIL basic_strobes: b2b=%0d dual=%0d, expected 0 0", rd_b2b, dual_wr);
        end
    endtask

    task automatic test_edge_replicate;
        int r0, d0;
        logic [19:0] ea;
        r0 = rd_total; d0 = done_total;
        lat_mode = 0;
        pulse_start(11'd7, 10'd8, 10'd7, 20'h00200, 20'h00010, 1'b1);
        wait_done(d0, 200, "edge");
        for (int k = 0; k < 4; k++) begin
            ea = 20'h00270 + 20'(k % 2);
            checks++;
            if (rd_log[r0 + k] !== ea) begin
                errors++;
                $display("FAIL edge_addr[%0d]: got %h, expected %h", k, rd_log[r0 + k], ea);
            end
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (lb0_img[k] !== pix(20'h00270 + 20'(k)) || lb1_img[k] !== pix(20'h00270 + 20'(k))) begin
                errors++;
                $display("FAIL edge_data[%0d]: got %h/%h, expected %h", k, lb0_img[k], lb1_img[k],
                         pix(20'h00270 + 20'(k)));
            end
        end
        checks++;
        if (done_cyc - start_cyc != 9) begin
            errors++;
            $display("FAIL edge_latency: got %0d, expected 9", done_cyc - start_cyc);
        end
    endtask

    task automatic test_width_boundary;
        int r0, d0;
        r0 = rd_total; d0 = done_total;
        lat_mode = 0;
        pulse_start(11'd512, 10'd2, 10'd1, 20'h00300, 20'h00080, 1'b1);
        wait_done(d0, 1200, "bound");
        checks++;
        if (cfg_err !== 1'b0 || rd_total - r0 != 256) begin
            errors++;
            $display("FAIL bound_512: cfg_err=%b reads=%0d, expected 0 256", cfg_err, rd_total - r0);
        end
        checks++;
        if (rd_log[r0 + 255] !== 20'h003FF || rd_log[r0 + 128] !== 20'h00380) begin
            errors++;
            $display("FAIL bound_addr: got %h/%h, expected 003ff/00380", rd_log[r0 + 255], rd_log[r0 + 128]);
        end
    endtask

    task automatic test_clamp;
        int r0, w00, w10, d0;
        r0 = rd_total; w00 = wr0_total; w10 = wr1_total; d0 = done_total;
        lat_mode = 0;
        pulse_start(11'd600, 10'd4, 10'd0, 20'h00000, 20'h00200, 1'b1);
        wait_done(d0, 1200, "clamp");
        checks++;
        if (cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL clamp_err: got %b, expected 1", cfg_err);
        end
        checks++;
        if (wr0_total - w00 != 128 || wr1_total - w10 != 128 || rd_total - r0 != 256) begin
            errors++;
            $display("FAIL clamp_counts: wr %0d/%0d rd %0d, expected 128/128 256",
                     wr0_total - w00, wr1_total - w10, rd_total - r0);
        end
        checks++;
        if (last_wr_addr !== 10'd127) begin
            errors++;
            $display("FAIL clamp_last_addr: got %0d, expected 127", last_wr_addr);
        end
        checks++;
        if (rd_log[r0 + 127] !== 20'h0007F || rd_log[r0 + 255] !== 20'h0027F) begin
            errors++;
            $display("FAIL clamp_mem_addr: got %h/%h, expected 0007f/0027f", rd_log[r0 + 127], rd_log[r0 + 255]);
        end
        checks++;
        if (lb1_img[127] !== pix(20'h0027F) || done_cyc - start_cyc != 513) begin
            errors++;
            $display("FAIL clamp_tail: data %h lat %0d, expected %h 513", lb1_img[127], done_cyc - start_cyc,
                     pix(20'h0027F));
        end
    endtask

    task automatic test_zero_width;
        int r0, w00, w10, d0;
        r0 = rd_total; w00 = wr0_total; w10 = wr1_total; d0 = done_total;
        pulse_start(11'd0, 10'd8, 10'd3, 20'h00500, 20'h00010, 1'b1);
        wait_done(d0, 50, "zero");
        checks++;
        if (rd_total != r0 || wr0_total != w00 || wr1_total != w10) begin
            errors++;
            $display("FAIL zero_activity: rd %0d wr %0d/%0d, expected 0 0/0",
                     rd_total - r0, wr0_total - w00, wr1_total - w10);
        end
        checks++;
        if (done_cyc - start_cyc != 1 || done_total - d0 != 1) begin
            errors++;
            $display("FAIL zero_done: lat %0d count %0d, expected 1 1", done_cyc - start_cyc, done_total - d0);
        end
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL zero_cfg_err: got %b, expected 0", cfg_err);
        end
    endtask

    task automatic test_random_latency;
        int r0, w00, w10, d0;
        logic [19:0] ea;
        w00 = wr0_total; w10 = wr1_total;
        @(posedge clk);
        #1;
        spur_data  = 32'hDEADBEEF;
        spur_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 spur_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (wr0_total != w00 || wr1_total != w10 || busy !== 1'b0) begin
            errors++;
            $display("FAIL spurious_valid: wr %0d/%0d busy %b, expected 0/0 0",
                     wr0_total - w00, wr1_total - w10, busy);
        end
        r0 = rd_total; w00 = wr0_total; w10 = wr1_total; d0 = done_total;
        lat_mode = 1;
        pulse_start(11'd20, 10'd3, 10'd1, 20'hFFFF0, 20'h00010, 1'b1);
        repeat (2) @(posedge clk);
        pulse_start(11'd4, 10'd8, 10'd5, 20'h00900, 20'h00001, 1'b0);
        wait_done(d0, 500, "rand");
        repeat (20) @(negedge clk);
        checks++;
        if (done_total - d0 != 1 || rd_total - r0 != 10) begin
            errors++;
            $display("FAIL rand_counts: done %0d rd %0d, expected 1 10", done_total - d0, rd_total - r0);
        end
        checks++;
        if (wr0_total - w00 != 5 || wr1_total - w10 != 5) begin
            errors++;
            $display("FAIL rand_writes: got %0d/%0d, expected 5/5", wr0_total - w00, wr1_total - w10);
        end
        for (int k = 0; k < 10; k++) begin
            ea = (k < 5) ? 20'(k) : 20'h00010 + 20'(k - 5);
            checks++;
            if (rd_log[r0 + k] !== ea) begin
                errors++;
                $display("FAIL rand_addr[%0d]: got %h, expected %h", k, rd_log[r0 + k], ea);
            end
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (lb0_img[k] !== pix(20'(k)) || lb1_img[k] !== pix(20'h00010 + 20'(k))) begin
                errors++;
                $display("FAIL rand_data[%0d]: got %h/%h, expected %h/%h", k, lb0_img[k], lb1_img[k],
                         pix(20'(k)), pix(20'h00010 + 20'(k)));
            end
        end
    endtask

    task automatic test_reset_midfill;
        int r0, w00, w10, d0, n;
        logic [67:0] obs;
        logic [19:0] ea;
        r0 = rd_total; w00 = wr0_total; w10 = wr1_total; d0 = done_total;
        lat_mode = 2;
        pulse_start(11'd16, 10'd8, 10'd0, 20'h00040, 20'h00008, 1'b1);
        n = 0;
        while (rd_total < r0 + 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rd_total < r0 + 4) begin
            errors++;
            $display("FAIL midrst_wait: reads %0d, expected 4", rd_total - r0);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        obs = {mem_rd_en, mem_addr, lb0_wr_en, lb1_wr_en, lb_wr_addr, lb_wr_data, busy, done, cfg_err};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got %h, expected 0", obs);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (wr0_total - w00 != 3 || wr1_total != w10 || done_total != d0) begin
            errors++;
            $display("FAIL midrst_discard: wr %0d/%0d done %0d, expected 3/0 0",
                     wr0_total - w00, wr1_total - w10, done_total - d0);
        end
        r0 = rd_total; w00 = wr0_total; w10 = wr1_total; d0 = done_total;
        lat_mode = 0;
        pulse_start(11'd8, 10'd8, 10'd1, 20'h00040, 20'h00008, 1'b1);
        wait_done(d0, 200, "midrst_refill");
        for (int k = 0; k < 4; k++) begin
            ea = (k < 2) ? 20'h00048 + 20'(k) : 20'h00050 + 20'(k - 2);
            checks++;
            if (rd_log[r0 + k] !== ea) begin
                errors++;
                $display("FAIL refill_addr[%0d]: got %h, expected %h", k, rd_log[r0 + k], ea);
            end
        end
        checks++;
        if (wr0_total - w00 != 2 || wr1_total - w10 != 2 || done_cyc - start_cyc != 9) begin
            errors++;
            $display("FAIL refill_summary: wr %0d/%0d lat %0d, expected 2/2 9",
                     wr0_total - w00, wr1_total - w10, done_cyc - start_cyc);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        cfg_base   = '0;
        cfg_stride = '0;
        cfg_width  = '0;
        cfg_height = '0;
        cfg_row    = '0;
        spur_valid = 1'b0;
        spur_data  = '0;
        lat_mode   = 0;
        test_reset();
        test_basic();
        test_edge_replicate();
        test_width_boundary();
        test_clamp();
        test_zero_width();
        test_random_latency();
        test_reset_midfill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
